// File: rtl/next_state_pkg.sv
// Shared types and the next-state function for the next_state_logic slice.
//   ev_op_e     : event opcodes carried on ev_op
//   ns_fsm_e    : handshake sequencing states
//   ns_result_t : {err, next} returned by ns_compute
package next_state_pkg;

    typedef enum logic [1:0] {
        EV_HOLD    = 2'd0,
        EV_ADVANCE = 2'd1,
        EV_JUMP    = 2'd2,
        EV_CLEAR   = 2'd3
    } ev_op_e;

    typedef enum logic [2:0] {
        WAIT_ST,
        WAIT_EV,
        COMPUTE,
        SEND,
        RECOVER
    } ns_fsm_e;

    typedef struct packed {
        logic        err;
        logic [31:0] next;
    } ns_result_t;

    // Values are carried at 32 bits so the function is independent of WIDTH.
    // Out-of-range state or jump target is clamped to num_states-1 and flagged.
    function automatic ns_result_t ns_compute(input logic [31:0] state,
                                              input ev_op_e      op,
                                              input logic [31:0] target,
                                              input int unsigned num_states);
        ns_result_t  r;
        logic [31:0] s;
        r.err = 1'b0;
        s     = state;
        if (state >= num_states) begin
            s     = num_states - 1;
            r.err = 1'b1;
        end
        case (op)
            EV_HOLD:    r.next = s;
            EV_ADVANCE: r.next = (s == num_states - 1) ? '0 : s + 32'd1;
            EV_JUMP: begin
                if (target >= num_states) begin
                    r.next = num_states - 1;
                    r.err  = 1'b1;
                end else begin
                    r.next = target;
                end
            end
            default:    r.next = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/next_state_logic_ns_latency_cnt.sv
// Loadable down-counter with zero flag, used to pad forward and backward
// latency of the next-state handshake loop.
//   load/load_val : synchronous load (takes priority over dec)
//   dec           : decrement, saturating at zero
//   zero          : counter value is zero
module ns_latency_cnt #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/next_state_logic.sv
// Next-state generator: collects a current-state token, then an event token,
// computes the next state, and returns it on the ns channel with FL/BL
// latency padding.
//   st_*     : current-state token in (valid/ready/data)
//   ev_*     : event token in (valid/ready/op/target)
//   ns_*     : next-state token out (valid/ready/data)
//   busy     : FSM is not in WAIT_ST
//   xfer_cnt : completed ns transfers (wrapping)
//   err      : sticky illegal state/target flag, cleared only by reset
module next_state_logic
    import next_state_pkg::*;
#(
    parameter int unsigned WIDTH      = 3,
    parameter int unsigned NUM_STATES = 8,
    parameter int unsigned FL         = 2,
    parameter int unsigned BL         = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [WIDTH-1:0] st_data,
    input  logic             ev_valid,
    output logic             ev_ready,
    input  logic [1:0]       ev_op,
    input  logic [WIDTH-1:0] ev_target,
    output logic             ns_valid,
    input  logic             ns_ready,
    output logic [WIDTH-1:0] ns_data,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic             err
);

    // Counter holds at most max(FL,BL)-1, since the transition edge itself
    // supplies the final cycle of each wait.
    localparam int unsigned LAT_MAX = (FL > BL) ? FL : BL;
    localparam int unsigned LAT_W   = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX);
    localparam logic [LAT_W-1:0] FL_LOAD = LAT_W'(FL - 1);
    localparam logic [LAT_W-1:0] BL_LOAD = LAT_W'((BL > 0) ? BL - 1 : 0);

    ns_fsm_e          state_q, state_d;
    logic [WIDTH-1:0] st_q, st_d;
    logic [WIDTH-1:0] ns_data_q, ns_data_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
    logic             err_q, err_d;
    logic             st_ready_q, st_ready_d;
    logic             ev_ready_q, ev_ready_d;
    logic             ns_valid_q, ns_valid_d;
    logic             busy_q, busy_d;

    logic             lat_load, lat_dec, lat_zero;
    logic [LAT_W-1:0] lat_val;
    ns_result_t       calc;

    ns_latency_cnt #(.W(LAT_W)) u_lat (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lat_load),
        .load_val (lat_val),
        .dec      (lat_dec),
        .zero     (lat_zero)
    );

    always_comb begin
        calc       = ns_compute(32'(st_q), ev_op_e'(ev_op), 32'(ev_target), NUM_STATES);
        state_d    = state_q;
        st_d       = st_q;
        ns_data_d  = ns_data_q;
        xfer_cnt_d = xfer_cnt_q;
        err_d      = err_q;
        lat_load   = 1'b0;
        lat_val    = FL_LOAD;
        lat_dec    = 1'b0;
        case (state_q)
            WAIT_ST: begin
                if (st_valid) begin
                    st_d    = st_data;
                    state_d = WAIT_EV;
                end
            end
            WAIT_EV: begin
                if (ev_valid) begin
                    ns_data_d = WIDTH'(calc.next);
                    err_d     = err_q | calc.err;
                    lat_load  = 1'b1;
                    lat_val   = FL_LOAD;
                    state_d   = COMPUTE;
                end
            end
            COMPUTE: begin
                lat_dec = 1'b1;
                if (lat_zero) state_d = SEND;
            end
            SEND: begin
                if (ns_ready) begin
                    xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
                    if (BL == 0) begin
                        state_d = WAIT_ST;
                    end else begin
                        lat_load = 1'b1;
                        lat_val  = BL_LOAD;
                        state_d  = RECOVER;
                    end
                end
            end
            RECOVER: begin
                lat_dec = 1'b1;
                if (lat_zero) state_d = WAIT_ST;
            end
            default: state_d = WAIT_ST;
        endcase
        // Handshake outputs are registered from the next state so they
        // change on the same edge as the FSM.
        st_ready_d = (state_d == WAIT_ST);
        ev_ready_d = (state_d == WAIT_EV);
        ns_valid_d = (state_d == SEND);
        busy_d     = (state_d != WAIT_ST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_ST;
            st_q       <= '0;
            ns_data_q  <= '0;
            xfer_cnt_q <= '0;
            err_q      <= 1'b0;
            st_ready_q <= 1'b1;
            ev_ready_q <= 1'b0;
            ns_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            st_q       <= st_d;
            ns_data_q  <= ns_data_d;
            xfer_cnt_q <= xfer_cnt_d;
            err_q      <= err_d;
            st_ready_q <= st_ready_d;
            ev_ready_q <= ev_ready_d;
            ns_valid_q <= ns_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign st_ready = st_ready_q;
    assign ev_ready = ev_ready_q;
    assign ns_valid = ns_valid_q;
    assign ns_data  = ns_data_q;
    assign busy     = busy_q;
    assign xfer_cnt = xfer_cnt_q;
    assign err      = err_q;

endmodule
